io_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the I/O controller's internal peripheral bus (15-bit address, 16-bit data, write strobe).
- Shares the bus between up to four masters: host SPI pipeline, PS/2 scanner, video refresh fetch, and a spare.
- Grants one master at a time, holds the bus until the addressed peripheral signals ready, returns read data with a one-cycle acknowledge, and times out stalled accesses.

---
 rtl/io_bus_arbiter_if.sv | 32 +++
 rtl/io_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the I/O bus arbiter, its requesting masters and the peripheral bus.
// The arbiter takes the master modport because it drives the peripheral bus.
interface io_bus_arbiter_if #(
  parameter int pRequesters = 4,
  parameter int pAddrWidth  = 15,
  parameter int pDataWidth  = 16
);
  logic [pRequesters-1:0]            iReq;
  logic [pRequesters-1:0]            iWrite;
  logic [pRequesters*pAddrWidth-1:0] iAddr;
  logic [pRequesters*pDataWidth-1:0] iData;
  logic [pRequesters-1:0]            oGrant;
  logic [pRequesters-1:0]            oAck;
  logic                              oError;
  logic [pDataWidth-1:0]             oRData;
  logic [pAddrWidth-1:0]             oBusAddress;
  logic [pDataWidth-1:0]             oBusData;
  logic                              oBusWrite;
  logic                              oBusEnable;
  logic [pDataWidth-1:0]             iBusRData;
  logic                              iBusReady;

  modport master (
    input  iReq, iWrite, iAddr, iData, iBusRData, iBusReady,
    output oGrant, oAck, oError, oRData, oBusAddress, oBusData, oBusWrite, oBusEnable
  );

  modport slave (
    output iReq, iWrite, iAddr, iData, iBusRData, iBusReady,
    input  oGrant, oAck, oError, oRData, oBusAddress, oBusData, oBusWrite, oBusEnable
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and access sequencer for the I/O controller's internal peripheral bus.
// One owner at a time: IDLE grants, ACCESS waits for ready or timeout, DONE pulses the ack.
module io_bus_arbiter #(
  parameter int pRequesters = 4,
  parameter int pAddrWidth  = 15,
  parameter int pDataWidth  = 16,
  parameter int pTimeout    = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  io_bus_arbiter_if.master     bus
);
  localparam int IdxW = $clog2(pRequesters);
  localparam logic [7:0] TimeoutLast = 8'(pTimeout - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [pRequesters-1:0]  grant_q, grant_d;
  logic [pAddrWidth-1:0]   addr_q, addr_d;
  logic [pDataWidth-1:0]   data_q, data_d;
  logic                    write_q, write_d;
  logic [7:0]              count_q, count_d;
  logic                    error_q, error_d;
  logic [pDataWidth-1:0]   rdata_q, rdata_d;

  logic [pAddrWidth-1:0]   addr_arr [pRequesters];
  logic [pDataWidth-1:0]   data_arr [pRequesters];

  generate
    for (genvar gi = 0; gi < pRequesters; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.iAddr[gi*pAddrWidth +: pAddrWidth];
      assign data_arr[gi] = bus.iData[gi*pDataWidth +: pDataWidth];
    end
  endgenerate

  // Search starts just after the last owner so every waiting master gets its turn.
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand_idx;
  int              cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= pRequesters; k++) begin
      cand     = (int'(last_q) + k) % pRequesters;
      cand_idx = IdxW'(cand);
      if (!pick_valid && bus.iReq[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    count_d = count_q;
    error_d = error_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = ACCESS;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          addr_d            = addr_arr[pick_idx];
          data_d            = data_arr[pick_idx];
          write_d           = bus.iWrite[pick_idx];
          count_d           = '0;
        end
      end
      ACCESS: begin
        count_d = count_q + 8'd1;
        // Ready takes priority over a simultaneous request drop.
        if (bus.iBusReady) begin
          rdata_d = write_q ? '0 : bus.iBusRData;
          error_d = 1'b0;
          last_d  = owner_q;
          state_d = DONE;
        end else if (!bus.iReq[owner_q]) begin
          grant_d = '0;
          count_d = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (count_q == TimeoutLast) begin
          rdata_d = '1;
          error_d = 1'b1;
          last_d  = owner_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        error_d = 1'b0;
        rdata_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IdxW'(pRequesters - 1);
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      count_q <= '0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      count_q <= count_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are gated by state so they read zero outside ACCESS.
  assign bus.oGrant      = grant_q;
  assign bus.oAck        = (state_q == DONE) ? grant_q : '0;
  assign bus.oError      = error_q;
  assign bus.oRData      = rdata_q;
  assign bus.oBusEnable  = (state_q == ACCESS);
  assign bus.oBusAddress = (state_q == ACCESS) ? addr_q : '0;
  assign bus.oBusData    = (state_q == ACCESS) ? data_q : '0;
  assign bus.oBusWrite   = (state_q == ACCESS) && write_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: expected acks are queued when a request is raised
// and compared by a monitor whenever the arbiter pulses oAck.
module tb_io_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  io_bus_arbiter_if #(.pRequesters(4), .pAddrWidth(15), .pDataWidth(16)) bus ();

  io_bus_arbiter #(.pRequesters(4), .pAddrWidth(15), .pDataWidth(16), .pTimeout(16)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ack;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q [$];

  // Peripheral model: ready after lat access cycles (0 = never), data fixed or address-derived.
  int          lat = 0;
  int          acc_cyc = 0;
  logic        fixed_en = 1'b0;
  logic [15:0] fixed_rdata = 16'h0;

  always @(posedge clk) acc_cyc <= bus.oBusEnable ? acc_cyc + 1 : 0;

  assign bus.iBusRData = fixed_en ? fixed_rdata : ({1'b0, bus.oBusAddress} ^ 16'h5A00);
  assign bus.iBusReady = bus.oBusEnable && (lat != 0) && (acc_cyc == lat - 1);

  function automatic logic [15:0] exp_rd(input logic [14:0] a);
    return {1'b0, a} ^ 16'h5A00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] a, input logic e, input logic [15:0] d);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.rdata = d;
    exp_q.push_back(x);
  endtask

  task automatic set_master(input int i, input logic w, input logic [14:0] a, input logic [15:0] d);
    bus.iWrite[i]         = w;
    bus.iAddr[i*15 +: 15] = a;
    bus.iData[i*16 +: 16] = d;
  endtask

  task automatic wait_ack(output logic [3:0] who);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (bus.oAck == 4'b0 && n < 60);
    who = bus.oAck;
    chk("ack_seen", 32'(who != 4'b0), 32'h1);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_enable"}, 32'(bus.oBusEnable), 32'h0);
    chk({tag, "_addr"}, 32'(bus.oBusAddress), 32'h0);
    chk({tag, "_write"}, 32'(bus.oBusWrite), 32'h0);
  endtask

  // Monitor: every ack is a transaction and must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.oAck != 4'b0) begin
      exp_t e;
      $display("ack %b error %b rdata %h", bus.oAck, bus.oError, bus.oRData);
      chk("ack_onehot", 32'($onehot(bus.oAck)), 32'h1);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(bus.oAck), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("ack", 32'(bus.oAck), 32'(e.ack));
        chk("ack_error", 32'(bus.oError), 32'(e.err));
        chk("ack_rdata", 32'(bus.oRData), 32'(e.rdata));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] who;
    int n;
    bus.iReq   = '0;
    bus.iWrite = '0;
    bus.iAddr  = '0;
    bus.iData  = '0;

    // Reset state
    cyc();
    chk("rst_grant", 32'(bus.oGrant), 32'h0);
    chk("rst_ack", 32'(bus.oAck), 32'h0);
    chk("rst_error", 32'(bus.oError), 32'h0);
    chk("rst_rdata", 32'(bus.oRData), 32'h0);
    chk_idle_bus("rst");
    rst = 1'b0;
    cyc();
    chk("idle_grant", 32'(bus.oGrant), 32'h0);

    // Round robin: all four request, master 0 first after reset, then 1,2,3,0
    lat = 1;
    for (int i = 0; i < 4; i++) set_master(i, 1'b0, 15'(15'h0100 + i), 16'h0);
    push(4'b0001, 1'b0, exp_rd(15'h0100));
    push(4'b0010, 1'b0, exp_rd(15'h0101));
    push(4'b0100, 1'b0, exp_rd(15'h0102));
    push(4'b1000, 1'b0, exp_rd(15'h0103));
    push(4'b0001, 1'b0, exp_rd(15'h0100));
    bus.iReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(who);
      bus.iReq = bus.iReq & ~who;
      cyc();
      if (i == 0) bus.iReq = bus.iReq | who;
    end

    // Single read, ready in the first ACCESS cycle
    set_master(0, 1'b0, 15'h0012, 16'h0);
    fixed_en = 1'b1;
    fixed_rdata = 16'h00A5;
    push(4'b0001, 1'b0, 16'h00A5);
    bus.iReq = 4'b0001;
    cyc();
    chk("rd_grant", 32'(bus.oGrant), 32'h1);
    chk("rd_addr", 32'(bus.oBusAddress), 32'h0012);
    chk("rd_write", 32'(bus.oBusWrite), 32'h0);
    chk("rd_enable", 32'(bus.oBusEnable), 32'h1);
    cyc();
    chk("rd_ack_latency", 32'(bus.oAck), 32'h1);
    chk("done_grant", 32'(bus.oGrant), 32'h1);
    chk_idle_bus("done");
    bus.iReq = 4'b0000;
    cyc();
    chk("rd_after_grant", 32'(bus.oGrant), 32'h0);

    // Write from master 2, ready on the third ACCESS cycle; data changed mid-access
    set_master(2, 1'b1, 15'h0034, 16'hBEEF);
    fixed_rdata = 16'hCAFE;
    lat = 3;
    push(4'b0100, 1'b0, 16'h0000);
    bus.iReq = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wr_enable", 32'(bus.oBusEnable), 32'h1);
      chk("wr_write", 32'(bus.oBusWrite), 32'h1);
      chk("wr_data", 32'(bus.oBusData), 32'hBEEF);
      chk("wr_addr", 32'(bus.oBusAddress), 32'h0034);
      if (i == 0) set_master(2, 1'b0, 15'h0999, 16'h1234);
    end
    wait_ack(who);
    bus.iReq = 4'b0000;
    fixed_en = 1'b0;
    cyc();

    // Timeout on master 1; master 3 requests meanwhile and is served next
    lat = 0;
    set_master(1, 1'b0, 15'h0055, 16'h0);
    set_master(3, 1'b0, 15'h0077, 16'h0);
    push(4'b0010, 1'b1, 16'hFFFF);
    push(4'b1000, 1'b0, exp_rd(15'h0077));
    bus.iReq = 4'b0010;
    cyc();
    bus.iReq = 4'b1010;
    n = 0;
    while (bus.oBusEnable && n < 40) begin
      n++;
      cyc();
    end
    chk("to_enable_cycles", 32'(n), 32'd16);
    chk("to_ack", 32'(bus.oAck), 32'h2);
    bus.iReq = 4'b1000;
    lat = 1;
    cyc();
    chk("to_idle_grant", 32'(bus.oGrant), 32'h0);
    cyc();
    chk("to_next_grant", 32'(bus.oGrant), 32'h8);
    wait_ack(who);
    bus.iReq = 4'b0000;
    cyc();

    // Abort: owner drops its request in the second ACCESS cycle
    lat = 0;
    set_master(0, 1'b0, 15'h0009, 16'h0);
    bus.iReq = 4'b0001;
    cyc();
    chk("ab_enable", 32'(bus.oBusEnable), 32'h1);
    cyc();
    bus.iReq = 4'b0000;
    cyc();
    chk("ab_grant", 32'(bus.oGrant), 32'h0);
    chk_idle_bus("ab");
    cyc();
    chk("ab_grant2", 32'(bus.oGrant), 32'h0);

    // Ready and request drop in the same cycle: completes normally
    lat = 1;
    set_master(1, 1'b0, 15'h0011, 16'h0);
    push(4'b0010, 1'b0, exp_rd(15'h0011));
    bus.iReq = 4'b0010;
    cyc();
    bus.iReq = 4'b0000;
    wait_ack(who);
    cyc();

    // Owner keeps requesting through DONE and is re-granted
    set_master(3, 1'b0, 15'h0033, 16'h0);
    push(4'b1000, 1'b0, exp_rd(15'h0033));
    push(4'b1000, 1'b0, exp_rd(15'h0033));
    bus.iReq = 4'b1000;
    wait_ack(who);
    cyc();
    chk("hold_idle_grant", 32'(bus.oGrant), 32'h0);
    cyc();
    chk("hold_regrant", 32'(bus.oGrant), 32'h8);
    wait_ack(who);
    bus.iReq = 4'b0000;
    cyc();

    // Reset mid-access: outputs clear at once, no ack, master 0 wins afterwards
    lat = 0;
    set_master(2, 1'b0, 15'h0022, 16'h0);
    bus.iReq = 4'b0100;
    cyc();
    cyc();
    chk("rs_enable_before", 32'(bus.oBusEnable), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rs_grant", 32'(bus.oGrant), 32'h0);
    chk("rs_ack", 32'(bus.oAck), 32'h0);
    chk("rs_error", 32'(bus.oError), 32'h0);
    chk_idle_bus("rs");
    cyc();
    rst = 1'b0;
    lat = 1;
    set_master(0, 1'b0, 15'h0040, 16'h0);
    push(4'b0001, 1'b0, exp_rd(15'h0040));
    push(4'b0100, 1'b0, exp_rd(15'h0022));
    bus.iReq = 4'b0101;
    cyc();
    chk("rs_first_grant", 32'(bus.oGrant), 32'h1);
    wait_ack(who);
    bus.iReq = bus.iReq & ~who;
    wait_ack(who);
    bus.iReq = bus.iReq & ~who;
    cyc();
    cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
